// File: rtl/tt_pkg.sv
// ============================================================================
//  Module      : tt_pkg
//  Description : Shared types, sizes and row helpers for the truth-table sweep
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package tt_pkg;

    localparam int ROW_W    = 3;
    localparam int NUM_ROWS = 8;

    // Sweep FSM encoding, kept as plain constants for legacy netlist compatibility
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_SAMPLE = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // Row 0 lands in the code MSB
    function automatic logic [ROW_W-1:0] row_bit(input logic [ROW_W-1:0] r);
        return 3'd7 - r;
    endfunction

    // Returns {in1,in2,in3}; in1 is the row MSB
    function automatic logic [ROW_W-1:0] row_to_drv(input logic [ROW_W-1:0] r);
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tt_sweep_checker_sync2.sv
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchroniser, asynchronous active-low reset to 0
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/tt_sweep_checker.sv
// ============================================================================
//  Module      : tt_sweep_checker
//  Description : Sweeps a 3-input circuit through all rows and rebuilds its
//                8-bit truth-table code, flagging unstable rows
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tt_sweep_checker
    import tt_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 4,
    parameter int         SAMPLE_COUNT  = 3,
    parameter logic [7:0] EXPECTED_TT   = 8'h1E
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       drv_in1,
    output logic       drv_in2,
    output logic       drv_in3,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt_code,
    output logic       match,
    output logic       unstable
);

    localparam logic [7:0]       C_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       C_SAMPLE_LAST = 8'(SAMPLE_COUNT - 1);
    localparam logic [ROW_W-1:0] C_LAST_ROW    = ROW_W'(NUM_ROWS - 1);

    logic             w_sync;
    state_t           r_state,    w_state_nx;
    logic [ROW_W-1:0] r_row,      w_row_nx;
    logic [7:0]       r_cnt,      w_cnt_nx;
    logic [7:0]       r_tt,       w_tt_nx;
    logic             r_unstable, w_unstable_nx;
    logic [ROW_W-1:0] r_drv,      w_drv_nx;
    logic             r_done,     w_done_nx;
    logic             r_match,    w_match_nx;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (dut_out),
        .o_q   (w_sync)
    );

    always_comb begin
        w_state_nx    = r_state;
        w_row_nx      = r_row;
        w_cnt_nx      = r_cnt;
        w_tt_nx       = r_tt;
        w_unstable_nx = r_unstable;
        w_drv_nx      = r_drv;
        w_done_nx     = 1'b0;
        w_match_nx    = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_drv_nx = '0;
                if (r_state == ST_DONE) begin
                    w_match_nx = r_match;
                end
                if (start) begin
                    w_state_nx    = ST_SETTLE;
                    w_row_nx      = '0;
                    w_cnt_nx      = '0;
                    w_tt_nx       = '0;
                    w_unstable_nx = 1'b0;
                    w_drv_nx      = row_to_drv('0);
                    w_match_nx    = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == C_SETTLE_LAST) begin
                    w_state_nx = ST_SAMPLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            ST_SAMPLE: begin
                // First sample defines the row result; later ones only vote on stability
                if (r_cnt == 8'd0) begin
                    w_tt_nx[row_bit(r_row)] = w_sync;
                end else if (w_sync != r_tt[row_bit(r_row)]) begin
                    w_unstable_nx = 1'b1;
                end
                if (r_cnt == C_SAMPLE_LAST) begin
                    w_cnt_nx = '0;
                    if (r_row == C_LAST_ROW) begin
                        w_state_nx = ST_DONE;
                        w_drv_nx   = '0;
                        w_done_nx  = 1'b1;
                        w_match_nx = (w_tt_nx == EXPECTED_TT);
                    end else begin
                        w_state_nx = ST_SETTLE;
                        w_row_nx   = r_row + 3'd1;
                        w_drv_nx   = row_to_drv(r_row + 3'd1);
                    end
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_drv_nx   = '0;
            end
        endcase

        // Abort overrides everything; partial code and the stability flag survive
        if (abort) begin
            w_state_nx    = ST_IDLE;
            w_row_nx      = '0;
            w_cnt_nx      = '0;
            w_tt_nx       = r_tt;
            w_unstable_nx = r_unstable;
            w_drv_nx      = '0;
            w_done_nx     = 1'b0;
            w_match_nx    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_row      <= '0;
            r_cnt      <= '0;
            r_tt       <= '0;
            r_unstable <= 1'b0;
            r_drv      <= '0;
            r_done     <= 1'b0;
            r_match    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_row      <= w_row_nx;
            r_cnt      <= w_cnt_nx;
            r_tt       <= w_tt_nx;
            r_unstable <= w_unstable_nx;
            r_drv      <= w_drv_nx;
            r_done     <= w_done_nx;
            r_match    <= w_match_nx;
        end
    end

    assign drv_in1  = r_drv[2];
    assign drv_in2  = r_drv[1];
    assign drv_in3  = r_drv[0];
    assign busy     = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign done     = r_done;
    assign tt_code  = r_tt;
    assign match    = r_match;
    assign unstable = r_unstable;

endmodule

`default_nettype wire

// File: tb/tb_tt_sweep_checker.sv
// ============================================================================
//  Module      : tb_tt_sweep_checker
//  Description : Directed self-checking bench for tt_sweep_checker
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tt_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       drv_in1, drv_in2, drv_in3;
    logic       busy, done, match, unstable;
    logic [7:0] tt_code;
    logic       stuck = 1'b0;
    logic       glitch = 1'b0;
    logic       dut_out;

    int errors = 0;
    int checks = 0;

    // Circuit under characterisation: in1 ^ (in2 & in3), optionally stuck or glitched
    assign dut_out = stuck ? 1'b0 : ((drv_in1 ^ (drv_in2 & drv_in3)) ^ glitch);

    always #5 clk = ~clk;

    tt_sweep_checker #(
        .SETTLE_CYCLES (4),
        .SAMPLE_COUNT  (3),
        .EXPECTED_TT   (8'h1E)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .drv_in1  (drv_in1),
        .drv_in2  (drv_in2),
        .drv_in3  (drv_in3),
        .dut_out  (dut_out),
        .busy     (busy),
        .done     (done),
        .tt_code  (tt_code),
        .match    (match),
        .unstable (unstable)
    );

    // Start pulse is cycle 0; observes cycles 1..70 and records done timing and drive errors
    task automatic do_sweep(input int glitch_cyc, input int restart_cyc,
                            output int done_cyc, output int done_pulses, output int drv_bad);
        logic [2:0] exp_drv;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        done_cyc    = -1;
        done_pulses = 0;
        drv_bad     = 0;
        for (int c = 1; c <= 70; c++) begin
            glitch  = (c == glitch_cyc);
            start   = (c == restart_cyc);
            exp_drv = (c <= 56) ? 3'((c - 1) / 7) : 3'b000;
            if ({drv_in1, drv_in2, drv_in3} !== exp_drv) drv_bad++;
            if (done === 1'b1) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(posedge clk); #1;
        end
        glitch = 1'b0;
        start  = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done);
        end
        checks++;
        if (tt_code !== 8'h00) begin
            errors++; $display("FAIL reset_tt_code: got %h expected 00", tt_code);
        end
        checks++;
        if ({match, unstable, drv_in1, drv_in2, drv_in3} !== 5'b0) begin
            errors++; $display("FAIL reset_flags_drv: got %b expected 00000",
                               {match, unstable, drv_in1, drv_in2, drv_in3});
        end
    endtask

    task automatic test_ideal;
        int dc, dp, db;
        do_sweep(0, 0, dc, dp, db);
        checks++;
        if (dc !== 57) begin errors++; $display("FAIL ideal_done_cycle: got %0d expected 57", dc); end
        checks++;
        if (dp !== 1) begin errors++; $display("FAIL ideal_done_pulses: got %0d expected 1", dp); end
        checks++;
        if (db !== 0) begin errors++; $display("FAIL ideal_drv_sequence: got %0d bad cycles expected 0", db); end
        checks++;
        if (tt_code !== 8'h1E) begin errors++; $display("FAIL ideal_tt_code: got %h expected 1e", tt_code); end
        checks++;
        if (match !== 1'b1 || unstable !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL ideal_match_unstable_busy: got %b%b%b expected 100", match, unstable, busy);
        end
    endtask

    task automatic test_stuck;
        int dc, dp, db;
        stuck = 1'b1;
        do_sweep(0, 0, dc, dp, db);
        stuck = 1'b0;
        checks++;
        if (dc !== 57) begin errors++; $display("FAIL stuck_done_cycle: got %0d expected 57", dc); end
        checks++;
        if (tt_code !== 8'h00) begin errors++; $display("FAIL stuck_tt_code: got %h expected 00", tt_code); end
        checks++;
        if (match !== 1'b0) begin errors++; $display("FAIL stuck_match: got %b expected 0", match); end
    endtask

    task automatic test_glitch;
        int dc, dp, db;
        // Glitch in cycle 39 reaches the synchroniser output in cycle 41 = row 5, second sample
        do_sweep(39, 0, dc, dp, db);
        checks++;
        if (unstable !== 1'b1) begin errors++; $display("FAIL glitch_unstable: got %b expected 1", unstable); end
        checks++;
        if (tt_code !== 8'h1E) begin errors++; $display("FAIL glitch_tt_code: got %h expected 1e", tt_code); end
        checks++;
        if (match !== 1'b1) begin errors++; $display("FAIL glitch_match: got %b expected 1", match); end
    endtask

    task automatic test_abort;
        int pulses;
        int dc, dp, db;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        checks++;
        if ({busy, drv_in1, drv_in2, drv_in3, match} !== 5'b0) begin
            errors++; $display("FAIL abort_outputs: got %b expected 00000",
                               {busy, drv_in1, drv_in2, drv_in3, match});
        end
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); end
        do_sweep(0, 0, dc, dp, db);
        checks++;
        if (tt_code !== 8'h1E || dc !== 57) begin
            errors++; $display("FAIL abort_resweep: got tt=%h done=%0d expected tt=1e done=57", tt_code, dc);
        end
    endtask

    task automatic test_back_to_back;
        int dc, dp, db;
        // Machine sits in DONE here, so this also covers restart from DONE
        do_sweep(0, 20, dc, dp, db);
        checks++;
        if (dc !== 57 || dp !== 1) begin
            errors++; $display("FAIL restart_ignored_done: got cycle=%0d pulses=%0d expected 57/1", dc, dp);
        end
        checks++;
        if (db !== 0 || tt_code !== 8'h1E) begin
            errors++; $display("FAIL restart_ignored_result: got bad=%0d tt=%h expected 0/1e", db, tt_code);
        end
    endtask

    task automatic test_start_abort_idle;
        int bad;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy !== 1'b0 || done !== 1'b0 || {drv_in1, drv_in2, drv_in3} !== 3'b000) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL start_abort_idle: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_reset_mid;
        int dc, dp, db;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (47) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || {drv_in1, drv_in2, drv_in3} !== 3'b110 || tt_code !== 8'h1E) begin
            errors++; $display("FAIL midreset_pre: got busy=%b drv=%b tt=%h expected 1/110/1e",
                               busy, {drv_in1, drv_in2, drv_in3}, tt_code);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, match, unstable, drv_in1, drv_in2, drv_in3} !== 7'b0 || tt_code !== 8'h00) begin
            errors++; $display("FAIL midreset_async: got flags=%b tt=%h expected 0000000/00",
                               {busy, done, match, unstable, drv_in1, drv_in2, drv_in3}, tt_code);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        do_sweep(0, 0, dc, dp, db);
        checks++;
        if (dc !== 57 || tt_code !== 8'h1E || match !== 1'b1) begin
            errors++; $display("FAIL midreset_resweep: got done=%0d tt=%h match=%b expected 57/1e/1",
                               dc, tt_code, match);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        test_ideal;
        test_stuck;
        test_glitch;
        test_abort;
        test_back_to_back;
        test_start_abort_idle;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
